// File: rtl/cpu_vic.sv
// Small 16-bit sequencing core with a vectored interrupt controller.
// Multi-cycle fetch/decode/mem/writeback; level requests become pending on rising edges.
module cpu_vic #(
   parameter logic [15:0] RESET_PC = 16'h2000,
   parameter int          N_IRQ    = 4,
   parameter logic [15:0] IRQ_BASE = 16'h0010
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_ce,
   input  logic [15:0]      i_mem_read_data,
   input  logic             i_mem_ready,
   output logic             o_mem_req,
   output logic [15:0]      o_mem_addr,
   output logic [15:0]      o_mem_write_data,
   output logic             o_ram_we,
   input  logic [N_IRQ-1:0] i_irq,
   output logic [N_IRQ-1:0] o_irq_ack,
   output logic             o_halted
);

   // state    | meaning
   // S_RESET  | load reset pc, enable interrupts, clear pending
   // S_FETCH  | request instruction at pc until ready
   // S_DECODE | route to halt, memory access or writeback
   // S_MEM    | data load/store until ready
   // S_WB     | register write, pc update, interrupt entry
   // S_HALT   | stopped until an enabled interrupt is pending
   typedef enum logic [2:0] {S_RESET, S_FETCH, S_DECODE, S_MEM, S_WB, S_HALT} state_t;

   state_t           state, state_nxt;
   logic [15:0]      pc, ir, mem_data, int_ret_pc;
   logic             int_enable;
   logic [N_IRQ-1:0] pending, irq_prev;
   logic [15:0]      regs [16];

   logic [3:0]  opcode, rd_idx, rs_idx, rt_idx;
   logic [7:0]  imm;
   logic [15:0] rd_val, rs_val, rt_val, r12, r13;
   logic [15:0] pc_inc, br_target, data_addr, alu_out, next_pc, reg_wdata, irq_vector;
   logic        reg_we, is_reti, is_store, irq_any, take_irq;
   logic [2:0]  irq_sel;

   assign opcode    = ir[15:12];
   assign rd_idx    = ir[11:8];
   assign rs_idx    = ir[7:4];
   assign rt_idx    = ir[3:0];
   assign imm       = ir[7:0];
   assign rd_val    = regs[rd_idx];
   assign rs_val    = regs[rs_idx];
   assign rt_val    = regs[rt_idx];
   assign r12       = regs[12];
   assign r13       = regs[13];
   assign pc_inc    = pc + 16'd1;
   assign br_target = {r12[7:0], imm};
   assign data_addr = (opcode == 4'h8 || opcode == 4'h9) ? {r13[7:0], imm} : rt_val;
   assign is_reti   = (opcode == 4'hE) && (rd_idx == 4'h0);
   assign is_store  = (opcode == 4'h9) || (opcode == 4'hB);

   always_comb begin
      alu_out = 16'h0000;
      case (opcode[2:0])
         3'd1:    alu_out = rs_val + rt_val;
         3'd2:    alu_out = rs_val - rt_val;
         3'd3:    alu_out = rs_val & rt_val;
         3'd4:    alu_out = rs_val | rt_val;
         3'd5:    alu_out = rs_val ^ rt_val;
         3'd6:    alu_out = rs_val << rt_val[3:0];
         default: alu_out = 16'h0000;
      endcase
   end

   always_comb begin
      next_pc   = pc_inc;
      reg_we    = 1'b0;
      reg_wdata = alu_out;
      case (opcode)
         4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: reg_we = 1'b1;
         4'h7: begin
            reg_we    = 1'b1;
            reg_wdata = {8'h00, imm};
         end
         4'h8, 4'hA: begin
            reg_we    = 1'b1;
            reg_wdata = mem_data;
         end
         4'hC: if (rd_val == 16'h0000) next_pc = br_target;
         4'hD: if ($signed(rd_val) > 16'sd0) next_pc = br_target;
         4'hE: next_pc = is_reti ? int_ret_pc : rd_val;
         4'hF: begin
            reg_we    = 1'b1;
            reg_wdata = pc_inc;
            next_pc   = br_target;
         end
         default: ;
      endcase
   end

   always_comb begin
      irq_sel = 3'd0;
      for (int k = N_IRQ - 1; k >= 0; k--)
         if (pending[k]) irq_sel = 3'(k);
   end

   assign irq_any    = |pending;
   assign irq_vector = IRQ_BASE + {13'd0, irq_sel};
   // RETI never takes an interrupt in its own writeback; the next one will.
   assign take_irq   = i_ce && !i_rst && int_enable && irq_any &&
                       ((state == S_WB && !is_reti) || state == S_HALT);

   always_comb begin
      o_irq_ack = '0;
      for (int k = 0; k < N_IRQ; k++)
         o_irq_ack[k] = take_irq && (irq_sel == 3'(k));
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_RESET:  state_nxt = S_FETCH;
         S_FETCH:  if (i_mem_ready) state_nxt = S_DECODE;
         S_DECODE: begin
            if (opcode == 4'h0)           state_nxt = S_HALT;
            else if (opcode[3:2] == 2'b10) state_nxt = S_MEM;
            else                          state_nxt = S_WB;
         end
         S_MEM:    if (i_mem_ready) state_nxt = S_WB;
         S_WB:     state_nxt = S_FETCH;
         S_HALT:   if (take_irq) state_nxt = S_FETCH;
         default:  state_nxt = S_RESET;
      endcase
   end

   // No bus activity in cycles where the core is frozen or being reset.
   assign o_mem_req        = (state == S_FETCH || state == S_MEM) && i_ce && !i_rst;
   assign o_mem_addr       = (state == S_FETCH) ? pc : (state == S_MEM) ? data_addr : 16'h0000;
   assign o_ram_we         = (state == S_MEM) && is_store && i_ce && !i_rst;
   assign o_mem_write_data = rd_val;
   assign o_halted         = (state == S_HALT);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= S_RESET;
         pending  <= '0;
         irq_prev <= i_irq;
      end else if (i_ce) begin
         state    <= state_nxt;
         irq_prev <= i_irq;
         pending  <= (pending | (i_irq & ~irq_prev)) & ~o_irq_ack;
         case (state)
            S_RESET: begin
               pc         <= RESET_PC;
               int_enable <= 1'b1;
               pending    <= '0;
            end
            S_FETCH: if (i_mem_ready) ir <= i_mem_read_data;
            S_MEM:   if (i_mem_ready) mem_data <= i_mem_read_data;
            S_WB: begin
               if (take_irq) begin
                  int_ret_pc <= next_pc;
                  pc         <= irq_vector;
                  int_enable <= 1'b0;
               end else begin
                  pc <= next_pc;
                  if (is_reti) int_enable <= 1'b1;
               end
            end
            S_HALT: begin
               if (take_irq) begin
                  int_ret_pc <= pc_inc;
                  pc         <= irq_vector;
                  int_enable <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst && i_ce && state == S_WB && reg_we)
         regs[rd_idx] <= reg_wdata;
   end

endmodule

// File: tb/tb_cpu_vic.sv
// Directed bench for cpu_vic: runs a small program against a word memory model
// and checks register, pc, bus and interrupt behaviour at hand-derived points.
module tb_cpu_vic;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_ce  = 1'b1;
   logic [15:0] i_mem_read_data;
   logic        i_mem_ready;
   logic        o_mem_req;
   logic [15:0] o_mem_addr;
   logic [15:0] o_mem_write_data;
   logic        o_ram_we;
   logic [3:0]  i_irq = 4'b0000;
   logic [3:0]  o_irq_ack;
   logic        o_halted;

   logic [15:0] mem [0:65535];
   logic        ready_base = 1'b1;
   logic        stall_we   = 1'b0;
   int          n_vec = 0;
   int          n_err = 0;
   int          we_cycles = 0;
   int          wr_count = 0;
   logic [15:0] wr_addr = 16'h0000;
   logic [15:0] wr_data = 16'h0000;
   int          we_snap;
   logic        ok;

   cpu_vic #(.RESET_PC(16'h2000), .N_IRQ(4), .IRQ_BASE(16'h0010)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_ce(i_ce),
      .i_mem_read_data(i_mem_read_data), .i_mem_ready(i_mem_ready),
      .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
      .o_mem_write_data(o_mem_write_data), .o_ram_we(o_ram_we),
      .i_irq(i_irq), .o_irq_ack(o_irq_ack), .o_halted(o_halted)
   );

   always #5 i_clk = ~i_clk;

   assign i_mem_read_data = mem[o_mem_addr];
   assign i_mem_ready     = ready_base && !(stall_we && o_ram_we);

   always @(posedge i_clk) begin
      if (o_ram_we) we_cycles <= we_cycles + 1;
      if (o_ram_we && i_mem_ready && i_ce) begin
         wr_count <= wr_count + 1;
         wr_addr  <= o_mem_addr;
         wr_data  <= o_mem_write_data;
      end
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic wait_fetch(input logic [15:0] a, output logic found);
      found = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (o_mem_req && o_mem_addr == a) begin
            found = 1'b1;
            break;
         end
         @(negedge i_clk);
      end
   endtask

   task automatic wait_ack(output logic found);
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (o_irq_ack != 4'b0000) begin
            found = 1'b1;
            break;
         end
         @(negedge i_clk);
      end
   endtask

   task automatic wait_sig(input int which, output logic found);
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if ((which == 0 && o_halted) || (which == 1 && o_ram_we)) begin
            found = 1'b1;
            break;
         end
         @(negedge i_clk);
      end
   endtask

   initial begin
      for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
      mem[16'h2000] = 16'h7105;  // R1 = 5
      mem[16'h2001] = 16'h7D30;  // R13 = 30
      mem[16'h2002] = 16'h8200;  // R2 = mem[3000]
      mem[16'h2003] = 16'h9277;  // mem[3077] = R2
      mem[16'h2004] = 16'h0000;  // HALT
      mem[16'h2005] = 16'h1312;  // R3 = R1+R2
      mem[16'h2006] = 16'h2421;  // R4 = R2-R1
      mem[16'h2007] = 16'h3512;  // R5 = R1&R2
      mem[16'h2008] = 16'h4612;  // R6 = R1|R2
      mem[16'h2009] = 16'h5712;  // R7 = R1^R2
      mem[16'h200A] = 16'h7803;  // R8 = 3
      mem[16'h200B] = 16'h6918;  // R9 = R1<<R8
      mem[16'h200C] = 16'h7000;  // R0 = 0
      mem[16'h200D] = 16'h7C20;  // R12 = 20
      mem[16'h200E] = 16'hC020;  // R0==0 -> 2020
      mem[16'h2020] = 16'hC140;  // R1!=0, falls through
      mem[16'h2021] = 16'hD440;  // R4 negative, falls through
      mem[16'h2022] = 16'hD130;  // R1>0 -> 2030
      mem[16'h2030] = 16'hFA40;  // R10 = 2031, -> 2040
      mem[16'h2040] = 16'h7B50;  // R11 = 50
      mem[16'h2041] = 16'hAE0B;  // R14 = mem[R11]
      mem[16'h2042] = 16'hB60B;  // mem[R11] = R6
      mem[16'h2043] = 16'h7CFF;  // R12 = FF
      mem[16'h2044] = 16'hC0FF;  // -> FFFF
      mem[16'hFFFF] = 16'h7B60;  // R11 = 60, pc wraps to 0000
      mem[16'h0000] = 16'hEB00;  // -> R11
      mem[16'h0060] = 16'hEB00;  // spin
      mem[16'h0010] = 16'hE000;  // RETI
      mem[16'h0011] = 16'hE000;
      mem[16'h0012] = 16'hE000;
      mem[16'h3000] = 16'hABCD;
      mem[16'h0050] = 16'h1234;

      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0;
      check("rst_halted", {15'd0, o_halted}, 16'h0000);
      check("rst_we", {15'd0, o_ram_we}, 16'h0000);
      check("rst_req", {15'd0, o_mem_req}, 16'h0000);
      check("rst_ack", {12'd0, o_irq_ack}, 16'h0000);
      check("rst_pending", {12'd0, dut.pending}, 16'h0000);

      repeat (4) @(posedge i_clk);
      @(negedge i_clk);
      check("first_pc", dut.pc, 16'h2001);
      check("first_r1", dut.regs[1], 16'h0005);

      ready_base = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge i_clk);
         check("stall_addr", o_mem_addr, 16'h2001);
         check("stall_req", {15'd0, o_mem_req}, 16'h0001);
         check("stall_ir", dut.ir, 16'h7105);
      end
      ready_base = 1'b1;
      @(negedge i_clk);
      check("fetch_ir", dut.ir, 16'h7D30);

      wait_sig(0, ok);
      check("halt_seen", {15'd0, ok}, 16'h0001);
      check("halt_pc", dut.pc, 16'h2004);
      check("st_count", wr_count[15:0], 16'h0001);
      check("st_addr", wr_addr, 16'h3077);
      check("st_data", wr_data, 16'hABCD);
      check("st_we_cycles", we_cycles[15:0], 16'h0001);

      i_irq = 4'b0001;
      @(negedge i_clk);
      i_irq = 4'b0000;
      wait_ack(ok);
      check("irq0_seen", {15'd0, ok}, 16'h0001);
      check("irq0_ack", {12'd0, o_irq_ack}, 16'h0001);
      @(negedge i_clk);
      check("irq0_halted", {15'd0, o_halted}, 16'h0000);
      check("irq0_pc", dut.pc, 16'h0010);
      check("irq0_ret", dut.int_ret_pc, 16'h2005);
      check("irq0_ien", {15'd0, dut.int_enable}, 16'h0000);

      wait_fetch(16'h2040, ok);
      check("reach_2040", {15'd0, ok}, 16'h0001);
      check("alu_add", dut.regs[3], 16'hABD2);
      check("alu_sub", dut.regs[4], 16'hABC8);
      check("alu_and", dut.regs[5], 16'h0005);
      check("alu_or", dut.regs[6], 16'hABCD);
      check("alu_xor", dut.regs[7], 16'hABC8);
      check("alu_shl", dut.regs[9], 16'h0028);
      check("jal_link", dut.regs[10], 16'h2031);

      wait_fetch(16'h0000, ok);
      check("pc_wrap", {15'd0, ok}, 16'h0001);
      check("wrap_r11", dut.regs[11], 16'h0060);
      check("ld_rt", dut.regs[14], 16'h1234);
      check("st_rt_addr", wr_addr, 16'h0050);
      check("st_rt_data", wr_data, 16'hABCD);
      check("st_rt_count", wr_count[15:0], 16'h0002);

      wait_fetch(16'h0060, ok);
      check("reach_loop", {15'd0, ok}, 16'h0001);
      i_ce = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge i_clk);
         check("ce_req", {15'd0, o_mem_req}, 16'h0000);
         check("ce_pc", dut.pc, 16'h0060);
      end
      i_ce = 1'b1;

      i_irq = 4'b0110;
      wait_ack(ok);
      check("irq1_seen", {15'd0, ok}, 16'h0001);
      check("irq1_ack", {12'd0, o_irq_ack}, 16'h0002);
      @(negedge i_clk);
      check("irq1_pc", dut.pc, 16'h0011);
      check("irq1_ret", dut.int_ret_pc, 16'h0060);
      wait_ack(ok);
      check("irq2_seen", {15'd0, ok}, 16'h0001);
      check("irq2_ack", {12'd0, o_irq_ack}, 16'h0004);
      @(negedge i_clk);
      check("irq2_pc", dut.pc, 16'h0012);
      wait_fetch(16'h0060, ok);
      check("reti_back", {15'd0, ok}, 16'h0001);
      check("irq_pending", {12'd0, dut.pending}, 16'h0000);
      check("irq_ien", {15'd0, dut.int_enable}, 16'h0001);
      i_irq = 4'b0000;

      stall_we = 1'b1;
      mem[16'h2000] = 16'hB60B;
      i_rst = 1'b1;
      @(negedge i_clk);
      i_rst = 1'b0;
      wait_sig(1, ok);
      check("mst_we_seen", {15'd0, ok}, 16'h0001);
      repeat (2) @(negedge i_clk);
      check("mst_we_hold", {15'd0, o_ram_we}, 16'h0001);
      check("mst_addr", o_mem_addr, 16'h0060);
      mem[16'h2000] = 16'h0000;
      i_rst = 1'b1;
      we_snap = we_cycles;
      @(negedge i_clk);
      i_rst = 1'b0;
      @(negedge i_clk);
      check("mst_pc", dut.pc, 16'h2000);
      repeat (10) @(negedge i_clk);
      check("mst_no_we", 16'(we_cycles - we_snap), 16'h0000);
      check("mst_no_write", wr_count[15:0], 16'h0002);
      check("mst_halted", {15'd0, o_halted}, 16'h0001);
      stall_we = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cpu_vic.md
CPU_VIC -- requirements
Module: cpu_vic

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h2000, meaning PC loaded on reset.
REQ-002 SHALL have parameter N_IRQ, default 4, meaning interrupt channel count, legal range 1..8.
REQ-003 SHALL have parameter IRQ_BASE, default 16'h0010, meaning vector of channel k is IRQ_BASE+k.
REQ-004 SHALL have ports: i_clk in 1 clock; i_rst in 1 reset; i_ce in 1 clock enable; i_mem_read_data in 16 read data; i_mem_ready in 1 memory access complete; o_mem_req out 1 access request; o_mem_addr out 16 address; o_mem_write_data out 16 store data; o_ram_we out 1 write strobe; i_irq in N_IRQ level requests; o_irq_ack out N_IRQ one-hot acknowledge; o_halted out 1 halt flag.
REQ-005 SHALL use one clock, i_clk; i_rst SHALL be synchronous and active-high.

Function
REQ-006 SHALL hold all state when i_ce=0, except that i_rst acts regardless of i_ce.
REQ-007 SHALL decode ir as opcode[15:12], d[11:8], s[7:4], t[3:0], imm[7:0], with 16 x 16-bit registers and the team ALU on opcode[2:0].
REQ-008 Opcodes: 0 HALT; 1-6 Rd<=ALU(Rs,Rt); 7 Rd<=zero-extended imm; 8 Rd<=mem[(R13<<8)+imm]; 9 mem[(R13<<8)+imm]<=Rd; A Rd<=mem[Rt]; B mem[Rt]<=Rd; C if Rd==0 pc<=(R12<<8)+imm; D if Rd signed >0, same target; E d!=0 pc<=Rd; E d==0 RETI; F Rd<=pc+1, pc<=(R12<<8)+imm.
REQ-009 Non-branching instructions and untaken branches SHALL set pc<=pc+1, wrapping 16'hFFFF to 0.
REQ-010 FSM states SHALL be RESET, FETCH, DECODE, MEM, WB, HALT.
REQ-011 RESET SHALL load pc<=RESET_PC, set int_enable=1, clear pending, and go to FETCH.
REQ-012 FETCH SHALL drive o_mem_req=1 with o_mem_addr=pc, hold both until i_mem_ready=1, then latch ir and go to DECODE.
REQ-013 DECODE SHALL go to HALT on opcode 0, to MEM on opcodes 8-B, and to WB otherwise.
REQ-014 MEM SHALL drive o_mem_req=1 with the computed address, pulse o_ram_we=1 for opcodes 9/B in every MEM cycle up to and including the i_mem_ready cycle, capture load data on i_mem_ready, then go to WB.
REQ-015 o_mem_req SHALL be 0 and o_mem_addr SHALL be 0 outside FETCH and MEM; o_mem_write_data SHALL equal Rd.
REQ-016 WB SHALL commit the register write, for opcodes 1-8, A and F only, and pc update in one cycle, then go to FETCH.
REQ-017 A channel k SHALL become pending on a rising edge of i_irq[k] and stay pending until acknowledged.
REQ-018 In WB with int_enable=1 and any channel pending, the CPU SHALL select the lowest pending index k, set int_ret_pc<=next_pc, pc<=IRQ_BASE+k, int_enable<=0, clear pending[k], and pulse o_irq_ack[k] for exactly that one cycle.
REQ-019 RETI SHALL set pc<=int_ret_pc and int_enable<=1; an interrupt pending during the RETI WB SHALL NOT be taken until the next WB.
REQ-020 HALT SHALL drive o_halted=1 and stay there until a channel is pending with int_enable=1, then clear o_halted and take the interrupt as in REQ-018, with int_ret_pc = halt address + 1.
REQ-021 A rising edge on i_irq[k] while k is already pending SHALL be absorbed; edges SHALL be detected even while i_ce=0 is not required.

Reset
REQ-022 On i_rst=1 the FSM SHALL enter RESET next cycle, abandoning any FETCH/MEM wait.
REQ-023 After that reset cycle, o_halted, o_ram_we, o_mem_req and o_irq_ack SHALL be 0 and pending SHALL be all-zero.
REQ-024 A reset asserted mid-store SHALL NOT produce a further o_ram_we after the reset cycle; register contents are not cleared by reset.

Verification
REQ-025 Reset, then memory with 0 wait states, then 7105 at 2000 -> R1=0005 and pc=2001 after 5 clocks.
REQ-026 Hold i_mem_ready=0 for 3 cycles during FETCH -> o_mem_addr stays 2000 and ir is unchanged until ready.
REQ-027 With R13=0030, execute 9277 (store R2=ABCD) -> exactly one write of ABCD to address 3077 with o_ram_we high only in MEM.
REQ-028 Raise i_irq[2] and i_irq[1] in the same cycle, N_IRQ=4 -> o_irq_ack=0010 and pc=0011; after RETI, ack 0100 and pc=0012.
REQ-029 HALT at 2004, then pulse i_irq[0] -> o_halted falls, pc=0010, and int_ret_pc=2005.
REQ-030 Assert i_rst during a MEM wait on opcode B -> no o_ram_we afterward and pc=2000.
